// File: rtl/spi_byte_interface.sv
// rtl/spi_byte_interface.sv - SPI mode-3 byte shifter with held chip select; SPI_IF_LOOPBACK_EN selects mosi->rx loopback
module spi_byte_interface #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       begin_transmission,
  input  logic [7:0] send_data,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       chip_select,
  output logic       end_transmission,
  output logic [7:0] received_data
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP, HOLD} state_t;

  state_t        state, state_next;
  logic [DW-1:0] div_cnt, div_cnt_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    tx_sr, tx_sr_next;
  logic [7:0]    rx_sr, rx_sr_next;
  logic [7:0]    received_data_next;
  logic          sclk_next, mosi_next, cs_next, end_next;
  logic          div_done;
  logic          rx_bit;

  assign div_done = (div_cnt == DIV_LAST);

`ifdef SPI_IF_LOOPBACK_EN
  assign rx_bit = mosi;
`else
  assign rx_bit = miso;
`endif

  // State and output registers; every output is registered so the sensor sees glitch-free lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      div_cnt          <= '0;
      bit_cnt          <= '0;
      tx_sr            <= '0;
      rx_sr            <= '0;
      sclk             <= 1'b1;
      mosi             <= 1'b1;
      chip_select      <= 1'b1;
      end_transmission <= 1'b0;
      received_data    <= '0;
    end else begin
      state            <= state_next;
      div_cnt          <= div_cnt_next;
      bit_cnt          <= bit_cnt_next;
      tx_sr            <= tx_sr_next;
      rx_sr            <= rx_sr_next;
      sclk             <= sclk_next;
      mosi             <= mosi_next;
      chip_select      <= cs_next;
      end_transmission <= end_next;
      received_data    <= received_data_next;
    end
  end

  // Next-state logic; SCLK edges are issued on the transition that starts each phase.
  always_comb begin
    state_next         = state;
    div_cnt_next       = '0;
    bit_cnt_next       = bit_cnt;
    tx_sr_next         = tx_sr;
    rx_sr_next         = rx_sr;
    sclk_next          = sclk;
    mosi_next          = mosi;
    cs_next            = chip_select;
    end_next           = 1'b0;
    received_data_next = received_data;

    case (state)
      IDLE: begin
        if (begin_transmission) begin
          tx_sr_next   = send_data;
          bit_cnt_next = '0;
          cs_next      = 1'b0;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        if (div_done) begin
          sclk_next  = 1'b0;
          mosi_next  = tx_sr[7];
          tx_sr_next = {tx_sr[6:0], 1'b0};
          state_next = SHIFT;
        end else begin
          div_cnt_next = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (!div_done) begin
          div_cnt_next = div_cnt + 1'b1;
        end else if (!sclk) begin
          sclk_next    = 1'b1;
          rx_sr_next   = {rx_sr[6:0], rx_bit};
          bit_cnt_next = bit_cnt + 3'd1;
        end else if (bit_cnt == 3'd0) begin
          // bit_cnt wrapped to zero after the eighth rising edge
          end_next           = 1'b1;
          received_data_next = rx_sr;
          state_next         = DONE;
        end else begin
          sclk_next  = 1'b0;
          mosi_next  = tx_sr[7];
          tx_sr_next = {tx_sr[6:0], 1'b0};
        end
      end
      DONE: begin
        state_next = GAP;
      end
      GAP: begin
        if (begin_transmission) begin
          // Load the next byte and issue its first falling edge in one step.
          sclk_next    = 1'b0;
          mosi_next    = send_data[7];
          tx_sr_next   = {send_data[6:0], 1'b0};
          bit_cnt_next = '0;
          state_next   = SHIFT;
        end else begin
          mosi_next  = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (div_done) begin
          cs_next    = 1'b1;
          state_next = IDLE;
        end else begin
          div_cnt_next = div_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_byte_interface.sv
// tb/tb_spi_byte_interface.sv - directed bench for spi_byte_interface with a mode-3 sensor model
module tb_spi_byte_interface;

  localparam int CLK_DIV = 4;
`ifdef SPI_IF_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       begin_transmission = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       miso = 1'b1;
  logic       sclk, mosi, chip_select, end_transmission;
  logic [7:0] received_data;

  spi_byte_interface #(.CLK_DIV(CLK_DIV)) dut (
    .clk                (clk),
    .rst                (rst),
    .begin_transmission (begin_transmission),
    .send_data          (send_data),
    .miso               (miso),
    .sclk               (sclk),
    .mosi               (mosi),
    .chip_select        (chip_select),
    .end_transmission   (end_transmission),
    .received_data      (received_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] sl);
    return LOOPBACK ? tx : sl;
  endfunction

  // Sensor model: shifts miso out on falling SCLK, captures mosi on rising SCLK.
  logic [7:0] sl_q[$];
  logic [7:0] sl_log[$];
  logic [7:0] sl_cur = 8'hFF;
  logic [7:0] sl_rsr = 8'h00;
  int         sl_sb = 0;
  int         sl_rb = 0;
  logic       prev_sclk = 1'b1;

  always @(negedge clk) begin
    if (chip_select) begin
      sl_sb = 0;
      sl_rb = 0;
    end else begin
      if (prev_sclk && !sclk) begin
        if (sl_sb == 0) sl_cur = (sl_q.size() > 0) ? sl_q.pop_front() : 8'hFF;
        miso   = sl_cur[7];
        sl_cur = {sl_cur[6:0], 1'b0};
        sl_sb  = (sl_sb + 1) % 8;
      end
      if (!prev_sclk && sclk) begin
        sl_rsr = {sl_rsr[6:0], mosi};
        sl_rb++;
        if (sl_rb == 8) begin
          sl_log.push_back(sl_rsr);
          sl_rb = 0;
        end
      end
    end
    prev_sclk = sclk;
  end

  // Monitor: logs end_transmission pulses, received bytes and chip_select rises.
  int         et_cyc[$];
  logic [7:0] rd_log[$];
  int         cs_rise_cyc[$];
  logic       prev_cs = 1'b1;

  always @(negedge clk) begin
    if (end_transmission) begin
      et_cyc.push_back(cyc);
      rd_log.push_back(received_data);
    end
    if (chip_select && !prev_cs) cs_rise_cyc.push_back(cyc);
    prev_cs = chip_select;
  end

  logic [7:0] tx_q[$];

  task automatic clear_logs();
    sl_q.delete();
    sl_log.delete();
    et_cyc.delete();
    rd_log.delete();
    cs_rise_cyc.delete();
    tx_q.delete();
  endtask

  // Plays the controller: holds begin_transmission through tx_q, or drops it drop_after cycles into the frame.
  task automatic run_frame(input int drop_after, output int c0);
    int t;
    int n;
    n = tx_q.size();
    send_data = tx_q[0];
    begin_transmission = 1'b1;
    t = 0;
    while (chip_select && t < 200) begin @(negedge clk); t++; end
    check("cs_low", {31'd0, chip_select}, 32'd0);
    c0 = cyc;
    if (drop_after >= 0) begin
      repeat (drop_after) @(negedge clk);
      begin_transmission = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!end_transmission && t < 400) begin @(negedge clk); t++; end
      if (!end_transmission) begin
        check("et_timeout", 32'd0, 32'd1);
        break;
      end
      if (i + 1 < n && drop_after < 0) send_data = tx_q[i+1];
      else begin_transmission = 1'b0;
      @(negedge clk);
      if (drop_after >= 0) break;
    end
    t = 0;
    while (!chip_select && t < 200) begin @(negedge clk); t++; end
    check("cs_high_end", {31'd0, chip_select}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  int c0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sclk", {31'd0, sclk}, 32'd1);
    check("rst_mosi", {31'd0, mosi}, 32'd1);
    check("rst_cs", {31'd0, chip_select}, 32'd1);
    check("rst_et", {31'd0, end_transmission}, 32'd0);
    check("rst_rd", {24'd0, received_data}, 32'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0xA5 out, 0x3C in
    clear_logs();
    tx_q.push_back(8'hA5);
    sl_q.push_back(8'h3C);
    run_frame(-1, c0);
    check("single_et_count", et_cyc.size(), 32'd1);
    check("single_et_latency", et_cyc[0] - c0, 32'd68);
    check("single_rd", {24'd0, rd_log[0]}, {24'd0, exp_rx(8'hA5, 8'h3C)});
    check("single_mosi", {24'd0, sl_log[0]}, 32'hA5);
    check("single_cs_rise", cs_rise_cyc[0] - et_cyc[0], 32'd6);
    check("single_rd_hold", {24'd0, received_data}, {24'd0, exp_rx(8'hA5, 8'h3C)});

    // Two-byte write in one frame
    clear_logs();
    tx_q.push_back(8'h20); tx_q.push_back(8'h4F);
    sl_q.push_back(8'h11); sl_q.push_back(8'h22);
    run_frame(-1, c0);
    check("two_et_count", et_cyc.size(), 32'd2);
    check("two_et_spacing", et_cyc[1] - et_cyc[0], 32'd66);
    check("two_cs_rises", cs_rise_cyc.size(), 32'd1);
    check("two_log0", {24'd0, sl_log[0]}, 32'h20);
    check("two_log1", {24'd0, sl_log[1]}, 32'h4F);
    check("two_rd1", {24'd0, rd_log[1]}, {24'd0, exp_rx(8'h4F, 8'h22)});

    // Burst read: address 0xE8 then six bytes
    clear_logs();
    tx_q.push_back(8'hE8);
    sl_q.push_back(8'h00);
    for (int i = 1; i <= 6; i++) begin
      tx_q.push_back(8'h00);
      sl_q.push_back(8'(i));
    end
    run_frame(-1, c0);
    check("burst_et_count", et_cyc.size(), 32'd7);
    check("burst_cs_rises", cs_rise_cyc.size(), 32'd1);
    check("burst_addr", {24'd0, sl_log[0]}, 32'hE8);
    for (int i = 1; i <= 6; i++)
      check($sformatf("burst_rd%0d", i), {24'd0, rd_log[i]}, {24'd0, exp_rx(8'h00, 8'(i))});

    // begin_transmission dropped during bit 2 of the first byte
    clear_logs();
    tx_q.push_back(8'hC3); tx_q.push_back(8'h99);
    sl_q.push_back(8'h5A);
    run_frame(CLK_DIV + 4 * CLK_DIV + 1, c0);
    repeat (20) @(negedge clk);
    check("drop_et_count", et_cyc.size(), 32'd1);
    check("drop_cs_rises", cs_rise_cyc.size(), 32'd1);
    check("drop_log_count", sl_log.size(), 32'd1);
    check("drop_log0", {24'd0, sl_log[0]}, 32'hC3);
    check("drop_rd", {24'd0, rd_log[0]}, {24'd0, exp_rx(8'hC3, 8'h5A)});
    check("drop_cs_rise_at", cs_rise_cyc[0] - et_cyc[0], 32'd6);

`ifdef SPI_IF_LOOPBACK_EN
    // Loopback with miso held low
    clear_logs();
    tx_q.push_back(8'h5A);
    sl_q.push_back(8'h00);
    run_frame(-1, c0);
    check("loop_rd", {24'd0, rd_log[0]}, 32'h5A);
`endif

    // Reset during bit 3
    clear_logs();
    tx_q.push_back(8'hFF);
    send_data = 8'hFF;
    begin_transmission = 1'b1;
    for (int t = 0; t < 200 && chip_select; t++) @(negedge clk);
    repeat (CLK_DIV + 6 * CLK_DIV + 2) @(negedge clk);
    check("mid_sclk_active", {31'd0, chip_select}, 32'd0);
    rst = 1'b1;
    begin_transmission = 1'b0;
    @(negedge clk);
    check("mid_rst_sclk", {31'd0, sclk}, 32'd1);
    check("mid_rst_cs", {31'd0, chip_select}, 32'd1);
    check("mid_rst_et", {31'd0, end_transmission}, 32'd0);
    check("mid_rst_mosi", {31'd0, mosi}, 32'd1);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("mid_no_et", et_cyc.size(), 32'd0);
    check("mid_cs_idle", {31'd0, chip_select}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
